// File: rtl/nubus_vram_arb.sv
// SDRAM request arbiter merging the nubus_video VRAM port with the host memory port.
// Enforces the VRAM address window, bounds video latency and aborts stalled transactions.
module nubus_vram_arb #(
    parameter logic [24:0] VRAM_BASE  = 25'h300000,
    parameter int unsigned VRAM_WORDS = 153600,
    parameter int unsigned MAX_WAIT   = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:0] h_addr,
    input  logic [15:0] h_wdata,
    input  logic [1:0]  h_be,
    input  logic        h_rd,
    input  logic        h_wr,
    output logic [15:0] h_rdata,
    output logic        h_ready,
    input  logic [24:0] v_addr,
    input  logic [15:0] v_wdata,
    input  logic        v_rd,
    input  logic        v_wr,
    output logic [15:0] v_rdata,
    output logic        v_ready,
    output logic        sd_req,
    output logic        sd_we,
    output logic [24:0] sd_addr,
    output logic [15:0] sd_wdata,
    output logic [1:0]  sd_be,
    input  logic [15:0] sd_rdata,
    input  logic        sd_ack,
    output logic        err_timeout,
    input  logic        err_clr
);
    localparam int unsigned AW = 25;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;
    localparam logic [AW-1:0] VRAM_END   = VRAM_BASE + AW'(VRAM_WORDS);
    localparam logic [CW-1:0] MAX_WAIT_C = CW'(MAX_WAIT);
    localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic          gnt_v_q, gnt_v_d;
    logic          sd_req_q, sd_req_d;
    logic          sd_we_q, sd_we_d;
    logic [AW-1:0] sd_addr_q, sd_addr_d;
    logic [DW-1:0] sd_wdata_q, sd_wdata_d;
    logic [1:0]    sd_be_q, sd_be_d;
    logic [DW-1:0] h_rdata_q, h_rdata_d;
    logic          h_ready_q, h_ready_d;
    logic [DW-1:0] v_rdata_q, v_rdata_d;
    logic          v_ready_q, v_ready_d;
    logic          err_q, err_d;
    logic [CW-1:0] vwait_q, vwait_d;
    logic [CW-1:0] tcnt_q, tcnt_d;

    logic h_pend_c, v_pend_c, v_in_win_c, pick_v_c;
    logic [DW-1:0] rd_result_c;

    assign h_pend_c   = h_rd | h_wr;
    assign v_pend_c   = v_rd | v_wr;
    assign v_in_win_c = (v_addr >= VRAM_BASE) && (v_addr < VRAM_END);
    // Host wins ties until video has waited long enough
    assign pick_v_c   = v_pend_c && (!h_pend_c || (vwait_q >= MAX_WAIT_C));

    always_comb begin
        state_d     = state_q;
        gnt_v_d     = gnt_v_q;
        sd_req_d    = sd_req_q;
        sd_we_d     = sd_we_q;
        sd_addr_d   = sd_addr_q;
        sd_wdata_d  = sd_wdata_q;
        sd_be_d     = sd_be_q;
        h_rdata_d   = h_rdata_q;
        h_ready_d   = 1'b0;
        v_rdata_d   = v_rdata_q;
        v_ready_d   = 1'b0;
        err_d       = err_clr ? 1'b0 : err_q;
        tcnt_d      = tcnt_q;
        vwait_d     = vwait_q;
        rd_result_c = sd_we_q ? '0 : sd_rdata;

        unique case (state_q)
            S_IDLE: begin
                if (h_pend_c || v_pend_c) begin
                    gnt_v_d = pick_v_c;
                    tcnt_d  = '0;
                    if (!pick_v_c) begin
                        sd_addr_d  = h_addr;
                        sd_wdata_d = h_wdata;
                        sd_be_d    = h_be;
                        sd_we_d    = h_wr;
                        sd_req_d   = 1'b1;
                        state_d    = S_WAIT;
                    end else if (v_in_win_c) begin
                        sd_addr_d  = v_addr;
                        sd_wdata_d = v_wdata;
                        sd_be_d    = 2'b11;
                        sd_we_d    = v_wr;
                        sd_req_d   = 1'b1;
                        state_d    = S_WAIT;
                    end else begin
                        // Outside the window: complete locally, never reach SDRAM
                        v_rdata_d = '0;
                        v_ready_d = 1'b1;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_WAIT: begin
                if (sd_ack) begin
                    sd_req_d = 1'b0;
                    state_d  = S_HOLD;
                    if (gnt_v_q) begin
                        v_rdata_d = rd_result_c;
                        v_ready_d = 1'b1;
                    end else begin
                        h_rdata_d = rd_result_c;
                        h_ready_d = 1'b1;
                    end
                end else if ((tcnt_q + CW'(1)) == TIMEOUT_C) begin
                    sd_req_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = S_HOLD;
                    if (gnt_v_q) begin
                        v_rdata_d = '1;
                        v_ready_d = 1'b1;
                    end else begin
                        h_rdata_d = '1;
                        h_ready_d = 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (gnt_v_q ? !v_pend_c : !h_pend_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Starvation counter: cleared whenever video is idle or being serviced
        if (!v_pend_c) begin
            vwait_d = '0;
        end else if ((state_q == S_IDLE && pick_v_c) || (state_q != S_IDLE && gnt_v_q)) begin
            vwait_d = '0;
        end else if (vwait_q != '1) begin
            vwait_d = vwait_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gnt_v_q    <= 1'b0;
            sd_req_q   <= 1'b0;
            sd_we_q    <= 1'b0;
            sd_addr_q  <= '0;
            sd_wdata_q <= '0;
            sd_be_q    <= 2'b11;
            h_rdata_q  <= '0;
            h_ready_q  <= 1'b0;
            v_rdata_q  <= '0;
            v_ready_q  <= 1'b0;
            err_q      <= 1'b0;
            vwait_q    <= '0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_v_q    <= gnt_v_d;
            sd_req_q   <= sd_req_d;
            sd_we_q    <= sd_we_d;
            sd_addr_q  <= sd_addr_d;
            sd_wdata_q <= sd_wdata_d;
            sd_be_q    <= sd_be_d;
            h_rdata_q  <= h_rdata_d;
            h_ready_q  <= h_ready_d;
            v_rdata_q  <= v_rdata_d;
            v_ready_q  <= v_ready_d;
            err_q      <= err_d;
            vwait_q    <= vwait_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign sd_req      = sd_req_q;
    assign sd_we       = sd_we_q;
    assign sd_addr     = sd_addr_q;
    assign sd_wdata    = sd_wdata_q;
    assign sd_be       = sd_be_q;
    assign h_rdata     = h_rdata_q;
    assign h_ready     = h_ready_q;
    assign v_rdata     = v_rdata_q;
    assign v_ready     = v_ready_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_nubus_vram_arb.sv
// Directed bench for nubus_vram_arb with a behavioural SDRAM responder.
module tb_nubus_vram_arb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [24:0] h_addr = '0;
    logic [15:0] h_wdata = '0;
    logic [1:0]  h_be = 2'b11;
    logic        h_rd = 1'b0;
    logic        h_wr = 1'b0;
    logic [15:0] h_rdata;
    logic        h_ready;
    logic [24:0] v_addr = '0;
    logic [15:0] v_wdata = '0;
    logic        v_rd = 1'b0;
    logic        v_wr = 1'b0;
    logic [15:0] v_rdata;
    logic        v_ready;
    logic        sd_req;
    logic        sd_we;
    logic [24:0] sd_addr;
    logic [15:0] sd_wdata;
    logic [1:0]  sd_be;
    logic [15:0] sd_rdata = '0;
    logic        sd_ack = 1'b0;
    logic        err_timeout;
    logic        err_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic        ack_en = 1'b1;
    int          ack_dly = 3;
    logic [15:0] ack_data = '0;
    int          wcnt = 0;

    always #5 clk = ~clk;

    nubus_vram_arb dut (
        .clk(clk), .reset(reset),
        .h_addr(h_addr), .h_wdata(h_wdata), .h_be(h_be), .h_rd(h_rd), .h_wr(h_wr),
        .h_rdata(h_rdata), .h_ready(h_ready),
        .v_addr(v_addr), .v_wdata(v_wdata), .v_rd(v_rd), .v_wr(v_wr),
        .v_rdata(v_rdata), .v_ready(v_ready),
        .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
        .sd_be(sd_be), .sd_rdata(sd_rdata), .sd_ack(sd_ack),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    // SDRAM model: one-cycle ack pulse ack_dly cycles after sd_req is seen
    always @(posedge clk) begin
        #1;
        if (sd_ack) begin
            sd_ack = 1'b0;
        end else if (sd_req && ack_en) begin
            wcnt++;
            if (wcnt >= ack_dly) begin
                sd_ack   = 1'b1;
                sd_rdata = ack_data;
                wcnt     = 0;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_h_ready(input int max, output int n);
        n = 0;
        while (!h_ready && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_v_ready(input int max, output int n);
        n = 0;
        while (!v_ready && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int p;
        int vg;
        logic late, req_prev, h_re, v_done, stop_h;

        // Reset state
        tick();
        tick();
        check("rst_sd_req", 32'(sd_req), 32'd0);
        check("rst_sd_we", 32'(sd_we), 32'd0);
        check("rst_sd_be", 32'(sd_be), 32'd3);
        check("rst_sd_addr", 32'(sd_addr), 32'd0);
        check("rst_h_rdata", 32'(h_rdata), 32'd0);
        check("rst_readys", 32'({h_ready, v_ready, err_timeout}), 32'd0);
        reset = 1'b0;
        tick();

        // Host read, ack three cycles after sd_req
        ack_dly = 3; ack_data = 16'hBEEF;
        h_addr = 25'h000100; h_rd = 1'b1;
        tick();
        check("hrd_req", 32'({sd_req, sd_we}), 32'b10);
        check("hrd_addr", 32'(sd_addr), 32'h000100);
        wait_h_ready(20, n);
        check("hrd_lat", 32'(n), 32'd3);
        check("hrd_data", 32'(h_rdata), 32'hBEEF);
        h_rd = 1'b0;
        tick();
        check("hrd_pulse", 32'({h_ready, sd_req}), 32'd0);
        tick();

        // Host write with partial byte enables
        h_addr = 25'h000200; h_wdata = 16'h55AA; h_be = 2'b01; h_wr = 1'b1;
        tick();
        check("hwr_bus", 32'({sd_req, sd_we, sd_be}), 32'b1101);
        check("hwr_wdata", 32'(sd_wdata), 32'h55AA);
        wait_h_ready(20, n);
        check("hwr_lat", 32'(n), 32'd3);
        check("hwr_rdata", 32'(h_rdata), 32'd0);
        h_wr = 1'b0; h_be = 2'b11;
        tick();
        tick();

        // Video write inside the window
        v_addr = 25'h300010; v_wdata = 16'h1234; v_wr = 1'b1;
        tick();
        check("vwr_bus", 32'({sd_req, sd_we, sd_be}), 32'b1111);
        check("vwr_addr", 32'(sd_addr), 32'h300010);
        check("vwr_wdata", 32'(sd_wdata), 32'h1234);
        wait_v_ready(20, n);
        check("vwr_lat", 32'(n), 32'd3);
        v_wr = 1'b0;
        tick();
        check("vwr_pulse", 32'(v_ready), 32'd0);
        tick();

        // Video read at the last in-window word
        ack_data = 16'hA5A5;
        v_addr = 25'h3257FF; v_rd = 1'b1;
        tick();
        check("vrd_last_req", 32'({sd_req, sd_we}), 32'b10);
        wait_v_ready(20, n);
        check("vrd_last_data", 32'(v_rdata), 32'hA5A5);
        v_rd = 1'b0;
        tick();
        tick();

        // Out-of-window video reads: below base and one past the end
        v_addr = 25'h2FFFFF; v_rd = 1'b1;
        tick();
        check("vlo_ready", 32'({v_ready, sd_req}), 32'b10);
        check("vlo_data", 32'(v_rdata), 32'd0);
        v_rd = 1'b0;
        tick();
        tick();
        v_addr = 25'h325800; v_rd = 1'b1;
        tick();
        check("vhi_ready", 32'({v_ready, sd_req}), 32'b10);
        check("vhi_data", 32'(v_rdata), 32'd0);
        v_rd = 1'b0;
        tick();
        tick();

        // Starvation: host re-requests continuously, video must win once it has waited 32 cycles
        ack_dly = 1;
        h_addr = 25'h000100; h_rd = 1'b1;
        tick();
        v_addr = 25'h300040; v_rd = 1'b1;
        p = cyc + 1;
        vg = -1; late = 1'b0; req_prev = sd_req; h_re = 1'b0; v_done = 1'b0; stop_h = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (sd_req && !req_prev) begin
                if (sd_addr == 25'h300040) begin
                    if (vg < 0) vg = cyc;
                end else if (vg < 0 && cyc >= p + 32) begin
                    late = 1'b1;
                end
            end
            req_prev = sd_req;
            if (h_ready) begin
                h_rd = 1'b0;
                h_re = !stop_h;
            end else if (h_re) begin
                h_rd = 1'b1;
                h_re = 1'b0;
            end
            if (v_ready) begin
                v_rd = 1'b0;
                v_done = 1'b1;
            end
            if (vg >= 0) stop_h = 1'b1;
        end
        check("starve_granted", 32'(vg >= 0), 32'd1);
        check("starve_not_early", 32'(vg >= p + 32), 32'd1);
        check("starve_not_late", 32'(late), 32'd0);
        check("starve_v_done", 32'(v_done), 32'd1);

        // Timeout: no ack ever
        ack_en = 1'b0;
        h_addr = 25'h000300; h_rd = 1'b1;
        tick();
        check("to_req", 32'(sd_req), 32'd1);
        n = 0;
        while (sd_req && n < 400) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n), 32'd255);
        check("to_ready_err", 32'({h_ready, err_timeout}), 32'b11);
        check("to_rdata", 32'(h_rdata), 32'hFFFF);
        h_rd = 1'b0;
        tick();
        check("to_sticky", 32'({h_ready, err_timeout}), 32'b01);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_clr", 32'(err_timeout), 32'd0);
        tick();

        // Reset while waiting on SDRAM
        h_addr = 25'h000500; h_rd = 1'b1;
        tick();
        check("rw_req", 32'(sd_req), 32'd1);
        tick();
        tick();
        reset = 1'b1; h_rd = 1'b0;
        tick();
        check("rw_drop", 32'({sd_req, h_ready}), 32'd0);
        reset = 1'b0;
        tick();
        check("rw_no_ready", 32'({sd_req, h_ready}), 32'd0);
        ack_en = 1'b1; ack_dly = 2; ack_data = 16'hCAFE;
        h_addr = 25'h000400; h_rd = 1'b1;
        tick();
        check("rw_next_addr", 32'(sd_addr), 32'h000400);
        wait_h_ready(20, n);
        check("rw_next_lat", 32'(n), 32'd2);
        check("rw_next_data", 32'(h_rdata), 32'hCAFE);
        h_rd = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
